// File: rtl/adc_pkg.sv
// Shared types and constants for the two-channel 10-bit serial ADC responder.
package adc_pkg;

    localparam int ADC_BITS = 10;
    localparam int CMD_BITS = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        CMD        = 3'd2,
        NULLB      = 3'd3,
        DATA_MSB   = 3'd4,
        DATA_LSB   = 3'd5,
        TAIL       = 3'd6
    } state_e;

    typedef struct packed {
        logic sgl;
        logic odd;
        logic msbf;
    } cmd_t;

endpackage

// File: rtl/adc_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous link line, with one-cycle
// rise/fall pulses taken from the synchronized copy.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_responder.sv
// Far-end responder for the 4-wire serial ADC link: decodes the start/command
// bits and shifts back a latched sample (single-ended or saturated difference).
module adc_responder
    import adc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 p_clk,
    input  logic                 p_cs,
    input  logic                 p_in,
    output logic                 p_out,
    input  logic [DATA_BITS-1:0] i_data0,
    input  logic [DATA_BITS-1:0] i_data1,
    output logic                 o_busy,
    output logic                 o_channel,
    output logic                 o_done,
    output logic                 o_abort
);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   word_q, word_d;
    cmd_t                   cmd_q, cmd_d;
    logic                   chan_q, chan_d;
    logic                   pout_q, pout_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic [SYNC_STAGES-1:0] in_sync_q;
    logic                   clk_rise, clk_fall, cs_rise, cs_fall, in_s;

    // Difference mode: 11-bit signed subtraction, negative results clamp to zero.
    function automatic logic [DATA_BITS-1:0] sat_sub(input logic [DATA_BITS-1:0] a,
                                                     input logic [DATA_BITS-1:0] b);
        logic signed [DATA_BITS:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return diff[DATA_BITS] ? '0 : diff[DATA_BITS-1:0];
    endfunction

    function automatic logic [DATA_BITS-1:0] pick_word(input logic sgl, input logic odd,
                                                       input logic [DATA_BITS-1:0] d0,
                                                       input logic [DATA_BITS-1:0] d1);
        logic [DATA_BITS-1:0] sel, other;
        sel   = odd ? d1 : d0;
        other = odd ? d0 : d1;
        return sgl ? sel : sat_sub(sel, other);
    endfunction

    sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .d_i    (p_clk),
        .rise_o (clk_rise),
        .fall_o (clk_fall)
    );

    // Only a fresh select fall starts a frame, so a frame cut by reset never resumes.
    sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .d_i    (p_cs),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    assign in_s = in_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        cmd_d   = cmd_q;
        chan_d  = chan_q;
        pout_d  = pout_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (cs_rise) begin
            state_d = IDLE;
            pout_d  = 1'b0;
            abort_d = state_q inside {CMD, NULLB, DATA_MSB};
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = WAIT_START;
                WAIT_START: if (clk_rise && in_s) begin
                    state_d = CMD;
                    cnt_d   = 4'(CMD_BITS - 1);
                end
                CMD: if (clk_rise) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd2) begin
                        cmd_d.sgl = in_s;
                    end else if (cnt_q == 4'd1) begin
                        cmd_d.odd = in_s;
                        chan_d    = in_s;
                    end else begin
                        cmd_d.msbf = in_s;
                        word_d     = pick_word(cmd_q.sgl, cmd_q.odd, i_data0, i_data1);
                        state_d    = NULLB;
                    end
                end
                NULLB: if (clk_fall) begin
                    pout_d  = 1'b0;
                    cnt_d   = 4'(ADC_BITS - 1);
                    state_d = DATA_MSB;
                end
                // Rotating left ten times restores the word for the LSB-first pass.
                DATA_MSB: if (clk_fall) begin
                    pout_d = word_q[DATA_BITS-1];
                    word_d = {word_q[DATA_BITS-2:0], word_q[DATA_BITS-1]};
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        done_d  = 1'b1;
                        cnt_d   = 4'(ADC_BITS - 2);
                        state_d = cmd_q.msbf ? TAIL : DATA_LSB;
                    end
                end
                DATA_LSB: if (clk_fall) begin
                    pout_d = word_q[1];
                    word_d = {word_q[0], word_q[DATA_BITS-1:1]};
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd0) state_d = TAIL;
                end
                TAIL: if (clk_fall) pout_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            word_q    <= '0;
            cmd_q     <= '0;
            chan_q    <= 1'b0;
            pout_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            in_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            cmd_q     <= cmd_d;
            chan_q    <= chan_d;
            pout_q    <= pout_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            in_sync_q <= {in_sync_q[SYNC_STAGES-2:0], p_in};
        end
    end

    assign p_out     = pout_q;
    assign o_busy    = state_q inside {CMD, NULLB, DATA_MSB, DATA_LSB, TAIL};
    assign o_channel = chan_q;
    assign o_done    = done_q;
    assign o_abort   = abort_q;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: an initiator model drives frames and the
// expected p_out bit stream is queued per frame and popped on each link rise.
module tb_adc_responder;

    localparam int PH = 8;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       p_clk = 1'b0;
    logic       p_cs  = 1'b1;
    logic       p_in  = 1'b0;
    logic       p_out;
    logic [9:0] i_data0 = '0;
    logic [9:0] i_data1 = '0;
    logic       o_busy, o_channel, o_done, o_abort;

    int n_chk = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int exp_q[$];

    adc_responder #(.SYNC_STAGES(2), .DATA_BITS(10)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .p_clk     (p_clk),
        .p_cs      (p_cs),
        .p_in      (p_in),
        .p_out     (p_out),
        .i_data0   (i_data0),
        .i_data1   (i_data1),
        .o_busy    (o_busy),
        .o_channel (o_channel),
        .o_done    (o_done),
        .o_abort   (o_abort)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_done)  done_cnt++;
        if (o_abort) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int model_word(input bit sgl, input bit odd,
                                      input logic [9:0] d0, input logic [9:0] d1);
        int sel, oth;
        sel = odd ? int'(d1) : int'(d0);
        oth = odd ? int'(d0) : int'(d1);
        if (sgl) return sel;
        return (sel - oth < 0) ? 0 : sel - oth;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pout"},  p_out,     0);
        chk({tag, "_busy"},  o_busy,    0);
        chk({tag, "_chan"},  o_channel, 0);
        chk({tag, "_done"},  o_done,    0);
        chk({tag, "_abort"}, o_abort,   0);
    endtask

    // cut < 0: full frame; otherwise stop after 'cut' data bits, then either
    // pulse reset (use_rst) or just raise select.
    task automatic run_frame(input bit sgl, input bit odd, input bit msbf, input int lead,
                             input int cut, input bit use_rst, input bit poke);
        int       w, total, ndata, done0, abort0;
        logic [3:0] cmdbits;
        w = model_word(sgl, odd, i_data0, i_data1);
        cmdbits = {1'b1, sgl, odd, msbf};
        exp_q.delete();
        exp_q.push_back(0);
        for (int i = 9; i >= 0; i--) exp_q.push_back((w >> i) & 1);
        if (!msbf) for (int i = 1; i <= 9; i++) exp_q.push_back((w >> i) & 1);
        exp_q.push_back(0);
        exp_q.push_back(0);
        total = lead + 4 + exp_q.size();
        ndata = 0;
        done0 = done_cnt;
        abort0 = abort_cnt;
        @(negedge i_clk) p_cs = 1'b0;
        repeat (PH) @(negedge i_clk);
        for (int k = 0; k < total; k++) begin
            p_in = (k >= lead && k < lead + 4) ? cmdbits[3 - (k - lead)] : 1'b0;
            repeat (PH) @(negedge i_clk);
            if (k == lead)     chk("busy_before_start", o_busy, 0);
            if (k == lead + 1) chk("busy_in_frame", o_busy, 1);
            if (k >= lead + 4) begin
                chk("pout", p_out, exp_q.pop_front());
                if (k >= lead + 5) ndata++;
            end
            p_clk = 1'b1;
            repeat (PH) @(negedge i_clk);
            if (poke && k == lead + 3) i_data0 = ~i_data0;
            p_clk = 1'b0;
            if (cut >= 0 && ndata == cut) break;
        end
        repeat (PH) @(negedge i_clk);
        if (use_rst) begin
            i_rst = 1'b1;
            @(negedge i_clk);
            i_rst = 1'b0;
            check_reset_outputs("midframe_rst");
        end
        p_cs = 1'b1;
        repeat (PH) @(negedge i_clk);
        chk("busy_after_cs", o_busy, 0);
        chk("pout_after_cs", p_out, 0);
        if (cut < 0) begin
            chk("done_pulses", done_cnt - done0, 1);
            chk("abort_pulses", abort_cnt - abort0, 0);
            chk("channel", o_channel, odd);
        end else if (!use_rst) begin
            chk("abort_pulses", abort_cnt - abort0, 1);
            chk("done_pulses_abort", done_cnt - done0, 0);
        end else begin
            chk("abort_after_rst", abort_cnt - abort0, 0);
        end
    endtask

    initial begin
        repeat (4) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check_reset_outputs("reset");

        i_data0 = 10'h2A5; i_data1 = 10'h155;
        run_frame(1'b1, 1'b0, 1'b1, 0, -1, 1'b0, 1'b0);

        i_data1 = 10'h301;
        run_frame(1'b1, 1'b1, 1'b0, 0, -1, 1'b0, 1'b0);

        i_data1 = 10'h100; i_data0 = 10'h180;
        run_frame(1'b0, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1, 0, -1, 1'b0, 1'b0);

        i_data0 = 10'h2A5;
        run_frame(1'b1, 1'b0, 1'b1, 3, -1, 1'b0, 1'b0);

        i_data1 = 10'h3C6;
        run_frame(1'b1, 1'b1, 1'b1, 0, 4, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, 1'b1, 0, -1, 1'b0, 1'b0);

        run_frame(1'b1, 1'b1, 1'b1, 0, 5, 1'b1, 1'b0);
        i_data0 = 10'h1E3;
        run_frame(1'b1, 1'b0, 1'b0, 0, -1, 1'b0, 1'b1);

        for (int r = 0; r < 3; r++) begin
            i_data0 = 10'($urandom_range(0, 1023));
            i_data1 = 10'($urandom_range(0, 1023));
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 0, -1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
